switch_allocator: RTL and testbench

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

---
 rtl/router_pkg.sv | 21 ++
 rtl/output_lock_unit.sv | 94 +++++++++
 rtl/switch_allocator.sv | 110 +++++++++++
 tb/tb_switch_allocator.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: packet type marker, output port numbering and
// the per-output lock state used by the switch allocator.
package router_pkg;

    localparam int PACKET_TYPE_WIDTH = 2;
    localparam logic [PACKET_TYPE_WIDTH-1:0] ROUTING_HEADER = 2'b01;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

endpackage

// File: rtl/output_lock_unit.sv
// One output port's allocator: round-robin grant among header requests,
// then holds the crossbar lock until the packet's last flit has transferred.
module output_lock_unit
    import router_pkg::*;
#(
    parameter int CHANNEL_NUMBER = 5,
    parameter int L_W            = 2,
    parameter int SEL_W          = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHANNEL_NUMBER-1:0]   req,
    input  logic [CHANNEL_NUMBER*L_W-1:0] len_all,
    input  logic [CHANNEL_NUMBER-1:0]   in_tvalid,
    input  logic                        out_tready,
    output logic                        out_tvalid,
    output logic [SEL_W-1:0]            out_sel,
    output logic [SEL_W-1:0]            owner,
    output lock_state_t                 state
);

    localparam logic [L_W:0] LEFT_ONE = {{L_W{1'b0}}, 1'b1};

    lock_state_t      state_q, state_n;
    logic [SEL_W-1:0] owner_q, owner_n;
    logic [SEL_W-1:0] rr_q, rr_n;
    logic [SEL_W-1:0] grant_idx;
    logic [L_W:0]     left_q, left_n;
    logic             grant_found;
    logic             xfer;
    int               idx;

    // Search starts just after the last served input, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 1; k <= CHANNEL_NUMBER; k++) begin
            idx = (int'(rr_q) + k) % CHANNEL_NUMBER;
            if (!grant_found && req[idx]) begin
                grant_found = 1'b1;
                grant_idx   = SEL_W'(idx);
            end
        end
    end

    assign xfer = (state_q == LOCKED) && in_tvalid[owner_q] && out_tready;

    always_comb begin
        state_n = state_q;
        owner_n = owner_q;
        left_n  = left_q;
        rr_n    = rr_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    state_n = LOCKED;
                    owner_n = grant_idx;
                    left_n  = {1'b0, len_all[int'(grant_idx)*L_W +: L_W]} + LEFT_ONE;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    left_n = left_q - LEFT_ONE;
                    if (left_q == LEFT_ONE) begin
                        state_n = IDLE;
                        rr_n    = owner_q;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            left_q  <= '0;
            rr_q    <= SEL_W'(CHANNEL_NUMBER - 1);
        end else begin
            state_q <= state_n;
            owner_q <= owner_n;
            left_q  <= left_n;
            rr_q    <= rr_n;
        end
    end

    assign out_tvalid = (state_q == LOCKED) && in_tvalid[owner_q];
    assign out_sel    = (state_q == LOCKED) ? owner_q : '0;
    assign owner      = owner_q;
    assign state      = state_q;

endmodule

// File: rtl/switch_allocator.sv
// Router switch allocator: XY-decodes each input's head flit, arbitrates per
// output with packet-granular locks and drives the crossbar selects.
module switch_allocator
    import router_pkg::*;
#(
    parameter int CHANNEL_NUMBER          = 5,
    parameter int DATA_WIDTH              = 32,
    parameter int MAX_ROUTERS_X           = 4,
    parameter int MAX_ROUTERS_Y           = 4,
    parameter int MAXIMUM_PACKAGES_NUMBER = 5,
    parameter int ROUTER_X                = 0,
    parameter int ROUTER_Y                = 0
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [CHANNEL_NUMBER-1:0]                      in_tvalid,
    input  logic [CHANNEL_NUMBER-1:0][DATA_WIDTH-1:0]      in_tdata,
    output logic [CHANNEL_NUMBER-1:0]                      in_tready,
    input  logic [CHANNEL_NUMBER-1:0]                      out_tready,
    output logic [CHANNEL_NUMBER-1:0]                      out_tvalid,
    output logic [CHANNEL_NUMBER-1:0][$clog2(CHANNEL_NUMBER)-1:0] out_sel,
    output logic [CHANNEL_NUMBER-1:0]                      orphan_err
);

    localparam int X_W     = $clog2(MAX_ROUTERS_X);
    localparam int Y_W     = $clog2(MAX_ROUTERS_Y);
    localparam int L_W     = $clog2(MAXIMUM_PACKAGES_NUMBER - 1);
    localparam int SEL_W   = $clog2(CHANNEL_NUMBER);
    localparam int LEN_LSB = 2 * (X_W + Y_W);

    logic [CHANNEL_NUMBER-1:0]       is_hdr;
    logic [CHANNEL_NUMBER-1:0]       owned;
    logic [CHANNEL_NUMBER-1:0]       locked;
    logic [CHANNEL_NUMBER*L_W-1:0]   len_all;
    logic [X_W-1:0]                  tgt_x [CHANNEL_NUMBER];
    logic [Y_W-1:0]                  tgt_y [CHANNEL_NUMBER];
    port_t                           dir   [CHANNEL_NUMBER];
    logic [CHANNEL_NUMBER-1:0]       req   [CHANNEL_NUMBER];
    logic [SEL_W-1:0]                owner [CHANNEL_NUMBER];
    lock_state_t                     state [CHANNEL_NUMBER];
    logic                            unused_data;

    // Payload bits outside the header fields carry no meaning for allocation.
    assign unused_data = ^in_tdata;

    always_comb begin
        is_hdr  = '0;
        len_all = '0;
        for (int i = 0; i < CHANNEL_NUMBER; i++) begin
            is_hdr[i] = (in_tdata[i][DATA_WIDTH-1 -: PACKET_TYPE_WIDTH] == ROUTING_HEADER);
            tgt_y[i]  = in_tdata[i][Y_W-1:0];
            tgt_x[i]  = in_tdata[i][Y_W +: X_W];
            len_all[i*L_W +: L_W] = in_tdata[i][LEN_LSB +: L_W];
            dir[i] = LOCAL;
            if (int'(tgt_x[i]) > ROUTER_X)      dir[i] = EAST;
            else if (int'(tgt_x[i]) < ROUTER_X) dir[i] = WEST;
            else if (int'(tgt_y[i]) > ROUTER_Y) dir[i] = NORTH;
            else if (int'(tgt_y[i]) < ROUTER_Y) dir[i] = SOUTH;
        end
    end

    always_comb begin
        owned     = '0;
        in_tready = '0;
        for (int o = 0; o < CHANNEL_NUMBER; o++) begin
            for (int i = 0; i < CHANNEL_NUMBER; i++) begin
                if (locked[o] && owner[o] == SEL_W'(i)) begin
                    owned[i] = 1'b1;
                    if (out_tready[o]) in_tready[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int o = 0; o < CHANNEL_NUMBER; o++) begin
            req[o] = '0;
            for (int i = 0; i < CHANNEL_NUMBER; i++) begin
                req[o][i] = in_tvalid[i] && is_hdr[i] && !owned[i] && (int'(dir[i]) == o);
            end
        end
    end

    for (genvar o = 0; o < CHANNEL_NUMBER; o++) begin : g_out
        output_lock_unit #(
            .CHANNEL_NUMBER (CHANNEL_NUMBER),
            .L_W            (L_W),
            .SEL_W          (SEL_W)
        ) u_unit (
            .clk        (clk),
            .rst        (rst),
            .req        (req[o]),
            .len_all    (len_all),
            .in_tvalid  (in_tvalid),
            .out_tready (out_tready[o]),
            .out_tvalid (out_tvalid[o]),
            .out_sel    (out_sel[o]),
            .owner      (owner[o]),
            .state      (state[o])
        );
        assign locked[o] = (state[o] == LOCKED);
    end

    // A body flit with no lock behind it means the upstream lost framing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) orphan_err <= '0;
        else     orphan_err <= orphan_err | (in_tvalid & ~is_hdr & ~owned);
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator at router (1,1): queue-fed inputs, a packet-level
// reference model of the allocation rules, and a per-output flit scoreboard.
module tb_switch_allocator;
    import router_pkg::*;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int SW = 3;
    localparam int RX = 1;
    localparam int RY = 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [N-1:0]         in_tvalid, in_tready, out_tready, out_tvalid, orphan_err;
    logic [N-1:0][DW-1:0] in_tdata;
    logic [N-1:0][SW-1:0] out_sel;

    always #5 clk = ~clk;

    switch_allocator #(
        .CHANNEL_NUMBER(N), .DATA_WIDTH(DW), .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4),
        .MAXIMUM_PACKAGES_NUMBER(5), .ROUTER_X(RX), .ROUTER_Y(RY)
    ) dut (
        .clk(clk), .rst(rst), .in_tvalid(in_tvalid), .in_tdata(in_tdata),
        .in_tready(in_tready), .out_tready(out_tready), .out_tvalid(out_tvalid),
        .out_sel(out_sel), .orphan_err(orphan_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] fifo  [N][$];
    logic [DW-1:0] exp_q [N][$];
    bit            stall [N];
    bit            rand_ready = 1'b0;

    int            m_owner [N];
    int            m_left  [N];
    int            m_last  [N];
    bit            m_orph  [N];
    logic [N-1:0]  m_ready;
    int            hs_cnt  [N];

    logic [N-1:0]         snap_tvalid, snap_tready, snap_orph;
    logic [N-1:0][SW-1:0] snap_sel;

    function automatic bit hdr_of(logic [DW-1:0] d);
        return d[DW-1 -: PACKET_TYPE_WIDTH] == ROUTING_HEADER;
    endfunction

    function automatic int len_of(logic [DW-1:0] d);
        return int'(d[9:8]);
    endfunction

    function automatic int route_of(logic [DW-1:0] d);
        int tx, ty;
        tx = int'(d[3:2]);
        ty = int'(d[1:0]);
        if (tx > RX) return int'(EAST);
        if (tx < RX) return int'(WEST);
        if (ty > RY) return int'(NORTH);
        if (ty < RY) return int'(SOUTH);
        return int'(LOCAL);
    endfunction

    function automatic logic [DW-1:0] mk_hdr(int tx, int ty, int len);
        logic [DW-1:0] d;
        d = $urandom;
        d[DW-1 -: PACKET_TYPE_WIDTH] = ROUTING_HEADER;
        d[1:0] = 2'(ty);
        d[3:2] = 2'(tx);
        d[9:8] = 2'(len);
        return d;
    endfunction

    function automatic logic [DW-1:0] mk_body();
        logic [DW-1:0] d;
        do d = $urandom; while (d[DW-1 -: PACKET_TYPE_WIDTH] == ROUTING_HEADER);
        return d;
    endfunction

    task automatic push_pkt(int i, int tx, int ty, int len);
        fifo[i].push_back(mk_hdr(tx, ty, len));
        repeat (len) fifo[i].push_back(mk_body());
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_owner[i] = -1;
            m_left[i]  = 0;
            m_last[i]  = N - 1;
            m_orph[i]  = 1'b0;
            stall[i]   = 1'b0;
            hs_cnt[i]  = 0;
            fifo[i].delete();
            exp_q[i].delete();
        end
        m_ready = '0;
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            if (fifo[i].size() > 0 && !stall[i]) begin
                in_tvalid[i] = 1'b1;
                in_tdata[i]  = fifo[i][0];
            end else begin
                in_tvalid[i] = 1'b0;
                in_tdata[i]  = $urandom;
            end
        end
        out_tready = rand_ready ? 5'($urandom) : '1;
    endtask

    task automatic check_ports();
        logic [N-1:0]         e_tv, e_rdy, e_orph;
        logic [N-1:0][SW-1:0] e_sel;
        logic [DW-1:0]        e;
        e_tv = '0; e_rdy = '0; e_orph = '0; e_sel = '0;
        for (int o = 0; o < N; o++) begin
            if (m_owner[o] >= 0) begin
                e_sel[o] = SW'(m_owner[o]);
                e_tv[o]  = in_tvalid[m_owner[o]];
                if (out_tready[o]) e_rdy[m_owner[o]] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) e_orph[i] = m_orph[i];
        n_checks += 4;
        if (out_tvalid !== e_tv) begin
            n_fail++; $display("FAIL out_tvalid @%0t: got %b expected %b", $time, out_tvalid, e_tv);
        end
        if (in_tready !== e_rdy) begin
            n_fail++; $display("FAIL in_tready @%0t: got %b expected %b", $time, in_tready, e_rdy);
        end
        if (orphan_err !== e_orph) begin
            n_fail++; $display("FAIL orphan_err @%0t: got %b expected %b", $time, orphan_err, e_orph);
        end
        if (out_sel !== e_sel) begin
            n_fail++; $display("FAIL out_sel @%0t: got %h expected %h", $time, out_sel, e_sel);
        end
        m_ready     = e_rdy;
        snap_tvalid = out_tvalid;
        snap_tready = in_tready;
        snap_orph   = orphan_err;
        snap_sel    = out_sel;
        for (int o = 0; o < N; o++) begin
            if (out_tvalid[o] === 1'b1 && out_tready[o]) begin
                hs_cnt[o]++;
                n_checks++;
                if (exp_q[o].size() == 0) begin
                    n_fail++; $display("FAIL data_extra out%0d @%0t: got %h expected none", o, $time, in_tdata[out_sel[o]]);
                end else begin
                    e = exp_q[o].pop_front();
                    if (in_tdata[out_sel[o]] !== e) begin
                        n_fail++; $display("FAIL data out%0d @%0t: got %h expected %h", o, $time, in_tdata[out_sel[o]], e);
                    end
                end
            end
        end
    endtask

    task automatic model_step();
        bit owned [N];
        bit found;
        int idx;
        for (int i = 0; i < N; i++) owned[i] = 1'b0;
        for (int o = 0; o < N; o++) if (m_owner[o] >= 0) owned[m_owner[o]] = 1'b1;
        for (int i = 0; i < N; i++)
            if (in_tvalid[i] && !hdr_of(in_tdata[i]) && !owned[i]) m_orph[i] = 1'b1;
        for (int o = 0; o < N; o++) begin
            if (m_owner[o] >= 0) begin
                if (in_tvalid[m_owner[o]] && out_tready[o]) begin
                    m_left[o]--;
                    if (m_left[o] == 0) begin
                        m_last[o]  = m_owner[o];
                        m_owner[o] = -1;
                    end
                end
            end else begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last[o] + k) % N;
                    if (!found && in_tvalid[idx] && hdr_of(in_tdata[idx]) &&
                        route_of(in_tdata[idx]) == o && !owned[idx]) begin
                        found      = 1'b1;
                        m_owner[o] = idx;
                        m_left[o]  = len_of(in_tdata[idx]) + 1;
                        for (int f = 0; f <= len_of(in_tdata[idx]); f++)
                            exp_q[o].push_back(fifo[idx][f]);
                    end
                end
            end
        end
        for (int i = 0; i < N; i++)
            if (m_ready[i] && in_tvalid[i]) void'(fifo[i].pop_front());
    endtask

    task automatic run_cycle();
        apply_inputs();
        #1;
        check_ports();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        n_checks += 4;
        if (out_tvalid !== '0) begin
            n_fail++; $display("FAIL rst_out_tvalid: got %b expected 0", out_tvalid);
        end
        if (in_tready !== '0) begin
            n_fail++; $display("FAIL rst_in_tready: got %b expected 0", in_tready);
        end
        if (out_sel !== '0) begin
            n_fail++; $display("FAIL rst_out_sel: got %h expected 0", out_sel);
        end
        if (orphan_err !== '0) begin
            n_fail++; $display("FAIL rst_orphan_err: got %b expected 0", orphan_err);
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) in_tdata[i] = mk_hdr(i % 4, 2, 1);
        in_tvalid  = '1;
        out_tready = '1;
        @(negedge clk);
        do_reset();
        repeat (2) run_cycle();
    endtask

    task automatic test_single_packet();
        bit seq [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        rand_ready = 1'b0;
        push_pkt(0, 2, 1, 2);
        for (int c = 0; c < 5; c++) begin
            run_cycle();
            n_checks += 3;
            if (snap_tvalid[EAST] !== seq[c]) begin
                n_fail++; $display("FAIL single_tvalid c%0d: got %b expected %b", c, snap_tvalid[EAST], seq[c]);
            end
            if (snap_tready[0] !== seq[c]) begin
                n_fail++; $display("FAIL single_tready c%0d: got %b expected %b", c, snap_tready[0], seq[c]);
            end
            if (snap_sel[EAST] !== 3'd0) begin
                n_fail++; $display("FAIL single_sel c%0d: got %0d expected 0", c, snap_sel[EAST]);
            end
        end
    endtask

    task automatic test_round_robin();
        int got_cyc [$];
        int got_sel [$];
        int ec [3] = '{1, 3, 5};
        int es [3] = '{1, 3, 1};
        do_reset();
        rand_ready = 1'b0;
        push_pkt(1, 1, 1, 0);
        push_pkt(1, 1, 1, 0);
        push_pkt(3, 1, 1, 0);
        for (int c = 0; c < 7; c++) begin
            run_cycle();
            if (snap_tvalid[LOCAL] === 1'b1) begin
                got_cyc.push_back(c);
                got_sel.push_back(int'(snap_sel[LOCAL]));
            end
        end
        n_checks++;
        if (got_cyc.size() != 3) begin
            n_fail++; $display("FAIL rr_count: got %0d expected 3", got_cyc.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks += 2;
                if (got_cyc[k] != ec[k]) begin
                    n_fail++; $display("FAIL rr_cycle%0d: got %0d expected %0d", k, got_cyc[k], ec[k]);
                end
                if (got_sel[k] != es[k]) begin
                    n_fail++; $display("FAIL rr_sel%0d: got %0d expected %0d", k, got_sel[k], es[k]);
                end
            end
        end
    endtask

    task automatic test_parallel();
        rand_ready = 1'b0;
        push_pkt(0, 2, 1, 1);
        push_pkt(2, 0, 1, 1);
        run_cycle();
        n_checks++;
        if (snap_tvalid[EAST] !== 1'b0 || snap_tvalid[WEST] !== 1'b0) begin
            n_fail++; $display("FAIL par_grant_cycle: got %b%b expected 00", snap_tvalid[EAST], snap_tvalid[WEST]);
        end
        run_cycle();
        n_checks += 2;
        if (snap_tvalid[EAST] !== 1'b1 || snap_tvalid[WEST] !== 1'b1) begin
            n_fail++; $display("FAIL par_tvalid: got %b%b expected 11", snap_tvalid[EAST], snap_tvalid[WEST]);
        end
        if (snap_sel[EAST] !== 3'd0 || snap_sel[WEST] !== 3'd2) begin
            n_fail++; $display("FAIL par_sel: got %0d,%0d expected 0,2", snap_sel[EAST], snap_sel[WEST]);
        end
        repeat (3) run_cycle();
    endtask

    task automatic test_stall();
        int budget;
        rand_ready = 1'b1;
        hs_cnt[NORTH] = 0;
        push_pkt(0, 1, 2, 3);
        budget = 0;
        while (hs_cnt[NORTH] < 2 && budget < 60) begin
            run_cycle();
            budget++;
        end
        n_checks++;
        if (hs_cnt[NORTH] < 2) begin
            n_fail++; $display("FAIL stall_start: got %0d handshakes expected 2", hs_cnt[NORTH]);
        end
        stall[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            run_cycle();
            n_checks++;
            if (snap_tvalid[NORTH] !== 1'b0) begin
                n_fail++; $display("FAIL stall_tvalid c%0d: got %b expected 0", c, snap_tvalid[NORTH]);
            end
        end
        stall[0] = 1'b0;
        budget = 0;
        while ((fifo[0].size() != 0 || exp_q[NORTH].size() != 0) && budget < 80) begin
            run_cycle();
            budget++;
        end
        rand_ready = 1'b0;
        run_cycle();
        n_checks += 2;
        if (hs_cnt[NORTH] != 4) begin
            n_fail++; $display("FAIL stall_flits: got %0d expected 4", hs_cnt[NORTH]);
        end
        if (snap_tvalid[NORTH] !== 1'b0) begin
            n_fail++; $display("FAIL stall_release: got %b expected 0", snap_tvalid[NORTH]);
        end
    endtask

    task automatic test_orphan();
        rand_ready = 1'b0;
        fifo[4].push_back(mk_body());
        run_cycle();
        n_checks++;
        if (snap_orph[4] !== 1'b0) begin
            n_fail++; $display("FAIL orphan_early: got %b expected 0", snap_orph[4]);
        end
        run_cycle();
        n_checks += 2;
        if (snap_orph[4] !== 1'b1) begin
            n_fail++; $display("FAIL orphan_set: got %b expected 1", snap_orph[4]);
        end
        if (snap_tready[4] !== 1'b0) begin
            n_fail++; $display("FAIL orphan_tready: got %b expected 0", snap_tready[4]);
        end
        do_reset();
        run_cycle();
    endtask

    task automatic test_reset_mid_packet();
        rand_ready = 1'b0;
        push_pkt(0, 2, 1, 3);
        repeat (3) run_cycle();
        do_reset();
        push_pkt(2, 2, 1, 0);
        run_cycle();
        n_checks++;
        if (snap_tvalid[EAST] !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_grant: got %b expected 0", snap_tvalid[EAST]);
        end
        run_cycle();
        n_checks += 2;
        if (snap_tvalid[EAST] !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_tvalid: got %b expected 1", snap_tvalid[EAST]);
        end
        if (snap_sel[EAST] !== 3'd2) begin
            n_fail++; $display("FAIL rstmid_sel: got %0d expected 2", snap_sel[EAST]);
        end
        run_cycle();
    endtask

    task automatic test_random();
        int  budget, pick;
        bit  busy;
        rand_ready = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                pick = $urandom_range(0, N - 1);
                if (fifo[pick].size() < 12)
                    push_pkt(pick, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            end
            for (int i = 0; i < N; i++) stall[i] = ($urandom_range(0, 9) == 0);
            run_cycle();
        end
        for (int i = 0; i < N; i++) stall[i] = 1'b0;
        budget = 0;
        busy   = 1'b1;
        while (busy && budget < 1000) begin
            run_cycle();
            budget++;
            busy = 1'b0;
            for (int i = 0; i < N; i++)
                if (fifo[i].size() != 0 || exp_q[i].size() != 0) busy = 1'b1;
        end
        n_checks++;
        if (busy) begin
            n_fail++; $display("FAIL random_drain: got pending flits expected none after %0d cycles", budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time %0t expected completion", $time);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        model_reset();
        test_reset();
        test_single_packet();
        test_round_robin();
        test_parallel();
        test_stall();
        test_orphan();
        test_reset_mid_packet();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
